// File: rtl/wb_regfile_unit.sv
// wb_regfile_unit: multi-port writeback stage with register file, EX forwarding copy and ecall handshake.
module wb_regfile_unit #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NPORTS = 2,
    parameter int NREAD  = 2,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NPORTS-1:0]      in_wbactive,
    input  logic [NPORTS*RW-1:0]   in_rd,
    input  logic [NPORTS*XLEN-1:0] in_aluresult,
    input  logic [NPORTS*XLEN-1:0] in_loaddata,
    input  logic [NPORTS-1:0]      in_dataselect,
    input  logic                   in_ecall,
    input  logic [NREAD*RW-1:0]    rd_idx,
    output logic [NREAD*XLEN-1:0]  rd_val,
    output logic [NPORTS-1:0]      fwd_active,
    output logic [NPORTS*RW-1:0]   fwd_rd,
    output logic [NPORTS*XLEN-1:0] fwd_val,
    output logic                   ecall_req,
    output logic [8*XLEN-1:0]      ecall_args,
    input  logic                   ecall_ack,
    input  logic [XLEN-1:0]        ecall_ret,
    output logic                   ecall_done
);
    if (NREGS < 18) begin : g_bad_nregs
        $error("NREGS must be at least 18");
    end

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e                   state_q, state_d;
    logic [XLEN-1:0]          regs_q [NREGS];
    logic [XLEN-1:0]          regs_d [NREGS];
    logic [NPORTS-1:0]        fwd_active_q, fwd_active_d;
    logic [NPORTS*RW-1:0]     fwd_rd_q, fwd_rd_d;
    logic [NPORTS*XLEN-1:0]   fwd_val_q, fwd_val_d;
    logic                     ecall_req_q, ecall_req_d;
    logic                     ecall_done_q, ecall_done_d;
    logic                     accept;

    assign in_ready = state_q == IDLE;
    assign accept   = in_valid && in_ready;

    // Ascending port order lets the highest-numbered port win on a shared rd.
    always_comb begin
        regs_d       = regs_q;
        fwd_active_d = '0;
        fwd_rd_d     = fwd_rd_q;
        fwd_val_d    = fwd_val_q;
        for (int p = 0; p < NPORTS; p++) begin
            if (accept) begin
                fwd_active_d[p]           = in_wbactive[p] && in_rd[p*RW +: RW] != '0;
                fwd_rd_d[p*RW +: RW]      = in_rd[p*RW +: RW];
                fwd_val_d[p*XLEN +: XLEN] = in_dataselect[p] ? in_loaddata[p*XLEN +: XLEN]
                                                             : in_aluresult[p*XLEN +: XLEN];
                if (fwd_active_d[p])
                    regs_d[in_rd[p*RW +: RW]] = fwd_val_d[p*XLEN +: XLEN];
            end
        end
        if (state_q == REQ && ecall_ack)
            regs_d[10] = ecall_ret;
        regs_d[0]    = '0;
        state_d      = state_q == IDLE ? ((accept && in_ecall) ? REQ : IDLE) :
                       state_q == REQ  ? (ecall_ack ? RESP : REQ) : IDLE;
        ecall_req_d  = state_d == REQ;
        ecall_done_d = state_d == RESP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            regs_q       <= '{default: '0};
            fwd_active_q <= '0;
            fwd_rd_q     <= '0;
            fwd_val_q    <= '0;
            ecall_req_q  <= 1'b0;
            ecall_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            fwd_active_q <= fwd_active_d;
            fwd_rd_q     <= fwd_rd_d;
            fwd_val_q    <= fwd_val_d;
            ecall_req_q  <= ecall_req_d;
            ecall_done_q <= ecall_done_d;
        end
    end

    assign fwd_active = fwd_active_q;
    assign fwd_rd     = fwd_rd_q;
    assign fwd_val    = fwd_val_q;
    assign ecall_req  = ecall_req_q;
    assign ecall_done = ecall_done_q;

    for (genvar r = 0; r < NREAD; r++) begin : g_rd
        assign rd_val[r*XLEN +: XLEN] = regs_d[rd_idx[r*RW +: RW]];
    end

    assign ecall_args[0 +: XLEN] = regs_q[17];
    for (genvar k = 1; k < 8; k++) begin : g_args
        assign ecall_args[k*XLEN +: XLEN] = regs_q[9+k];
    end
endmodule

// File: tb/tb_wb_regfile_unit.sv
// tb_wb_regfile_unit: directed self-checking bench for wb_regfile_unit.
module tb_wb_regfile_unit;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_wbactive = '0;
    logic [9:0]   in_rd = '0;
    logic [127:0] in_aluresult = '0;
    logic [127:0] in_loaddata = '0;
    logic [1:0]   in_dataselect = '0;
    logic         in_ecall = 1'b0;
    logic [9:0]   rd_idx = '0;
    logic [127:0] rd_val;
    logic [1:0]   fwd_active;
    logic [9:0]   fwd_rd;
    logic [127:0] fwd_val;
    logic         ecall_req;
    logic [511:0] ecall_args;
    logic         ecall_ack = 1'b0;
    logic [63:0]  ecall_ret = '0;
    logic         ecall_done;
    int           errs = 0;
    int           checks = 0;

    wb_regfile_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_wbactive(in_wbactive), .in_rd(in_rd), .in_aluresult(in_aluresult),
        .in_loaddata(in_loaddata), .in_dataselect(in_dataselect), .in_ecall(in_ecall),
        .rd_idx(rd_idx), .rd_val(rd_val), .fwd_active(fwd_active), .fwd_rd(fwd_rd),
        .fwd_val(fwd_val), .ecall_req(ecall_req), .ecall_args(ecall_args),
        .ecall_ack(ecall_ack), .ecall_ret(ecall_ret), .ecall_done(ecall_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_wbactive = '0; in_ecall = 1'b0; in_dataselect = '0;
    endtask

    initial begin
        #12 reset = 1'b1;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_fwd_active", 64'(fwd_active), 64'd0);
        chk("rst_req", 64'(ecall_req), 64'd0);
        chk("rst_done", 64'(ecall_done), 64'd0);
        step();
        // dual write, ALU on port0, load on port1
        in_valid = 1'b1; in_wbactive = 2'b11; in_rd = {5'd6, 5'd5};
        in_aluresult = {64'h99, 64'h11}; in_loaddata = {64'h22, 64'h33}; in_dataselect = 2'b10;
        rd_idx = {5'd6, 5'd5};
        #1;
        chk("dual_byp_x5", rd_val[63:0], 64'h11);
        chk("dual_byp_x6", rd_val[127:64], 64'h22);
        step();
        idle_in();
        #1;
        chk("dual_fwd_active", 64'(fwd_active), 64'd3);
        chk("dual_fwd_rd", 64'(fwd_rd), 64'({5'd6, 5'd5}));
        chk("dual_fwd_val0", fwd_val[63:0], 64'h11);
        chk("dual_fwd_val1", fwd_val[127:64], 64'h22);
        chk("dual_store_x5", rd_val[63:0], 64'h11);
        chk("dual_store_x6", rd_val[127:64], 64'h22);
        step();
        chk("idle_fwd_active", 64'(fwd_active), 64'd0);
        chk("idle_fwd_hold_rd", 64'(fwd_rd), 64'({5'd6, 5'd5}));
        chk("idle_fwd_hold_val", fwd_val[127:64], 64'h22);
        // conflict on x7
        in_valid = 1'b1; in_wbactive = 2'b11; in_rd = {5'd7, 5'd7};
        in_aluresult = {64'hB, 64'hA}; in_dataselect = 2'b00; rd_idx = {5'd7, 5'd7};
        #1;
        chk("conf_byp_x7", rd_val[63:0], 64'hB);
        step();
        // x0 write
        in_wbactive = 2'b01; in_rd = {5'd0, 5'd0}; in_aluresult = {64'h0, 64'hFF};
        rd_idx = {5'd7, 5'd0};
        #1;
        chk("x0_byp", rd_val[63:0], 64'h0);
        chk("conf_store_x7", rd_val[127:64], 64'hB);
        step();
        idle_in();
        #1;
        chk("x0_fwd_active", 64'(fwd_active), 64'd0);
        chk("x0_store", rd_val[63:0], 64'h0);
        // x17 = 93
        in_valid = 1'b1; in_wbactive = 2'b01; in_rd = {5'd0, 5'd17}; in_aluresult = {64'h0, 64'd93};
        step();
        // ecall with co-issued x10 <- 5
        in_rd = {5'd0, 5'd10}; in_aluresult = {64'h0, 64'd5}; in_ecall = 1'b1;
        step();
        // stalled beat attempting x5 <- 0xDEAD
        in_ecall = 1'b0; in_rd = {5'd0, 5'd5}; in_aluresult = {64'h0, 64'hDEAD};
        rd_idx = {5'd10, 5'd5};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("req%0d_req", i), 64'(ecall_req), 64'd1);
            chk($sformatf("req%0d_ready", i), 64'(in_ready), 64'd0);
            chk($sformatf("req%0d_a0", i), ecall_args[63:0], 64'd93);
            chk($sformatf("req%0d_a1", i), ecall_args[127:64], 64'd5);
            chk($sformatf("req%0d_x5", i), rd_val[63:0], 64'h11);
            if (i > 0) chk($sformatf("req%0d_fwd", i), 64'(fwd_active), 64'd0);
            step();
        end
        ecall_ack = 1'b1; ecall_ret = 64'h77;
        step();
        ecall_ack = 1'b0; idle_in();
        #1;
        chk("resp_done", 64'(ecall_done), 64'd1);
        chk("resp_req", 64'(ecall_req), 64'd0);
        chk("resp_ready", 64'(in_ready), 64'd0);
        chk("resp_x10", rd_val[127:64], 64'h77);
        chk("resp_x5", rd_val[63:0], 64'h11);
        step();
        chk("post_done", 64'(ecall_done), 64'd0);
        chk("post_ready", 64'(in_ready), 64'd1);
        // ack in IDLE is ignored
        ecall_ack = 1'b1; ecall_ret = 64'h55;
        step();
        ecall_ack = 1'b0;
        #1;
        chk("idle_ack_x10", rd_val[127:64], 64'h77);
        chk("idle_ack_done", 64'(ecall_done), 64'd0);
        // reset during REQ
        in_valid = 1'b1; in_ecall = 1'b1;
        step();
        idle_in();
        chk("rreq_req", 64'(ecall_req), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rreq_drop", 64'(ecall_req), 64'd0);
        chk("rreq_ready", 64'(in_ready), 64'd1);
        chk("rreq_x10", rd_val[127:64], 64'h0);
        chk("rreq_x5", rd_val[63:0], 64'h0);
        chk("rreq_fwd", 64'(fwd_active), 64'd0);
        #3 reset = 1'b1;
        ecall_ack = 1'b1; ecall_ret = 64'h99;
        step();
        ecall_ack = 1'b0;
        #1;
        chk("late_ack_done", 64'(ecall_done), 64'd0);
        chk("late_ack_x10", rd_val[127:64], 64'h0);
        chk("late_ack_req", 64'(ecall_req), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile_unit.md
# wb_regfile_unit

Parametrised writeback stage with an integrated register file. It commits up to `NPORTS` results per cycle from the MEM/WB boundary and serves `NREAD` combinational read ports to decode/execute. It also registers a per-port forwarding copy for EX. Environment calls go through a request/acknowledge handshake with an external service agent, and the return value is written back to a0.

## Interface
Parameters:
- `XLEN`, 64, data width of each register.
- `NREGS`, 32, register count. Index width `RW = $clog2(NREGS)`. Must be ≥ 18.
- `NPORTS`, 2, writeback channels per cycle.
- `NREAD`, 2, combinational read ports.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting low clears all state immediately.
- `in_valid`  in  1  MEM/WB beat present.
- `in_ready`  out  1  stage can accept a beat.
- `in_wbactive`  in  NPORTS  per-port write enable.
- `in_rd`  in  NPORTS*RW  per-port destination index (port p at bits [p*RW +: RW]).
- `in_aluresult`  in  NPORTS*XLEN  per-port ALU result.
- `in_loaddata`  in  NPORTS*XLEN  per-port load data.
- `in_dataselect`  in  NPORTS  per-port source select: 0 selects ALU, 1 selects load.
- `in_ecall`  in  1  beat carries an ecall.
- `rd_idx`  in  NREAD*RW  read indices.
- `rd_val`  out  NREAD*XLEN  read data.
- `fwd_active`  out  NPORTS  registered copy of committed port enables.
- `fwd_rd`  out  NPORTS*RW  registered copy of committed destinations.
- `fwd_val`  out  NPORTS*XLEN  registered copy of committed values.
- `ecall_req`  out  1  ecall service request.
- `ecall_args`  out  8*XLEN  slot 0 = x17, slots 1..7 = x10..x16.
- `ecall_ack`  in  1  service complete.
- `ecall_ret`  in  XLEN  value to write into x10.
- `ecall_done`  out  1  one-cycle completion pulse.

## Operation
Register file:
- `NREGS` entries. x0 always reads 0, and writes to x0 are dropped.
- Beat accept condition: `in_valid && in_ready`.
- On an accepted beat, each port p with `in_wbactive[p]=1` writes the `in_dataselect[p]`-selected value to `in_rd[p]`.
- If two or more ports target the same nonzero index in one beat, the highest-numbered port wins.
- Reads are write-first. `rd_val` returns the value being written this cycle when an accepted port targets `rd_idx`, using the same highest-port priority. Otherwise it returns the stored value.

Forwarding outputs:
- Registered every cycle.
- For an accepted beat: `fwd_active[p] = in_wbactive[p] && in_rd[p]!=0`, and `fwd_rd`/`fwd_val` carry the committed rd/value.
- For a non-accepted cycle: `fwd_active` = 0, and `fwd_rd`/`fwd_val` hold their previous values.

Ecall FSM (states IDLE, REQ, RESP):
- IDLE:
  - `in_ready` = 1.
  - An accepted beat with `in_ecall=1` first commits any port writes in the same beat, then moves to REQ.
- REQ:
  - `in_ready` = 0 and `ecall_req` = 1.
  - `ecall_args` is driven from the register file. No writes occur while in REQ, so it is stable.
  - On `ecall_ack=1`, write `ecall_ret` to x10 and move to RESP.
- RESP:
  - `in_ready` = 0 and `ecall_done` = 1 for this cycle only.
  - Unconditionally return to IDLE.
- `ecall_ack` outside REQ is ignored.

## Timing
- Reset (async, `reset` low):
  - all registers 0, FSM = IDLE;
  - `fwd_active`, `fwd_rd`, `fwd_val` = 0;
  - `ecall_req` = 0, `ecall_done` = 0;
  - `in_ready` = 1 once reset is released.
- A reset asserted mid-ecall aborts it: `ecall_req` drops asynchronously, and a later ack is ignored.
- Write latency: a beat accepted at edge N is visible in storage after edge N. It is visible on `rd_val` during cycle N via bypass.
- Forwarding: `fwd_*` is valid in the cycle after the commit edge.
- Ecall sequence:
  - accept at edge N;
  - `ecall_req` high from N+1;
  - with ack first sampled at edge M, `ecall_req` is low and `ecall_done` high in the cycle after M;
  - `in_ready` returns to 1 one cycle later.
- Minimum ecall occupancy is 3 cycles (ack returned in the first REQ cycle).
- `in_ready` is a pure function of FSM state, with no combinational path from `in_valid`.

## Test plan
- **Reset**: drive `reset` low mid-cycle → all `rd_val`=0, `fwd_active`=0, `in_ready`=1, without waiting for a clock edge.
- **Dual write**:
  - Stimulus: port0 x5←ALU 0x11, port1 x6←load 0x22, `in_dataselect`=2'b10.
  - Response: same-cycle `rd_val` (idx 5,6) = 0x11/0x22; next cycle `fwd_active`=2'b11 with matching `fwd_rd`/`fwd_val`.
- **Conflict and x0**:
  - Stimulus: both ports write x7 (0xA, 0xB), then a write of 0xFF to x0.
  - Response: x7=0xB; x0 reads 0 with `fwd_active`=0 for that port.
- **Stall**: `in_valid`=1 with `in_ready`=0 during an ecall → register file unchanged and `fwd_active`=0.
- **Ecall with co-issued write**:
  - Stimulus: x17=93; beat writes x10←5 with `in_ecall`=1; ack after 4 REQ cycles with `ecall_ret`=0x77.
  - Response: `ecall_args` slot0=93, slot1=5, stable for all REQ cycles; then `ecall_done` pulses once and x10 reads 0x77.
- **Reset during REQ**: pull `reset` low while in REQ → `ecall_req` drops immediately; a following ack produces no `ecall_done` and no write to x10.
